native_axi_bridge: RTL and testbench

NATIVE_AXI_BRIDGE -- requirements
Module: native_axi_bridge

---
 rtl/native_axi_bridge_pkg.sv | 31 +++
 rtl/native_axi_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_native_axi_bridge.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/native_axi_bridge_pkg.sv
// Shared bus constants for the native-to-AXI4 bridge.
// Holds the bridge FSM state encoding, the fixed AXI4 attribute values driven
// on every single-beat transfer, and the response decode helper.
package native_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } bridge_state_t;

  // Single-beat, 4-byte, INCR, normal non-secure data access
  localparam logic [0:0] AXI_ID         = 1'b0;
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [2:0] AXI_SIZE       = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic       AXI_LOCK       = 1'b0;
  localparam logic [3:0] AXI_CACHE      = 4'b0011;
  localparam logic [2:0] AXI_PROT       = 3'b010;
  localparam logic [3:0] AXI_QOS        = 4'd0;
  localparam logic       AXI_WLAST      = 1'b1;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/native_axi_bridge.sv
// Native valid/ready request port to AXI4 master bridge, one transaction in
// flight, single-beat 32-bit transfers only.
//
// Ports
//   clk, reset           : rising-edge clock, async active-high reset
//   valid/addr/wdata/wstrb: native request, held until ready; wstrb==0 is a read
//   rdata                : last read data, held through writes and idle
//   ready                : one-cycle completion pulse
//   err                  : sticky, set by any non-OKAY B or R response
//   m_axi_aw*/w*/b*      : AXI4 write channels
//   m_axi_ar*/r*         : AXI4 read channels
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for valid, latches the request
// ST_WR      | AW and W offered, each dropped on its own handshake
// ST_WR_RESP | bready high, waiting for B
// ST_RD_ADDR | arvalid high, waiting for arready
// ST_RD_DATA | rready high, waiting for R
// ST_DONE    | ready pulse; valid ignored here
module native_axi_bridge
  import native_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic [0:0]        m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic [3:0]        m_axi_awqos,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [0:0]        m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  bridge_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;

  // A channel counts as done if it was accepted earlier or is accepted now,
  // so AW and W completing on the same edge leaves WR in one step.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || m_axi_awready;
  assign w_w_done  = !r_wvalid  || m_axi_wready;

  // Single-beat transfers make rlast redundant; the byte offset is dropped by
  // word alignment.
  logic w_unused;
  assign w_unused = ^{m_axi_rlast, addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid) begin
            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            if (wstrb != 4'd0) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            if (resp_is_err(m_axi_bresp)) r_err <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rdata  <= m_axi_rdata;
            r_rready <= 1'b0;
            if (resp_is_err(m_axi_rresp)) r_err <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata         = r_rdata;
  assign ready         = r_ready;
  assign err           = r_err;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = AXI_LEN;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = AXI_LOCK;
  assign m_axi_awcache = AXI_CACHE;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awqos   = AXI_QOS;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = AXI_WLAST;
  assign m_axi_wvalid  = r_wvalid;

  assign m_axi_bready  = r_bready;

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = AXI_LEN;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = AXI_LOCK;
  assign m_axi_arcache = AXI_CACHE;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arqos   = AXI_QOS;
  assign m_axi_arvalid = r_arvalid;

  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_native_axi_bridge.sv
// Bench for native_axi_bridge: an AXI slave with programmable per-channel
// delays sits behind the bridge; a word-array reference memory with byte-lane
// merge and a sticky error flag predict every completion.
module tb_native_axi_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic [0:0]        m_axi_awid, m_axi_arid;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]        m_axi_awlen, m_axi_arlen;
  logic [2:0]        m_axi_awsize, m_axi_arsize;
  logic [1:0]        m_axi_awburst, m_axi_arburst;
  logic              m_axi_awlock, m_axi_arlock;
  logic [3:0]        m_axi_awcache, m_axi_arcache;
  logic [2:0]        m_axi_awprot, m_axi_arprot;
  logic [3:0]        m_axi_awqos, m_axi_arqos;
  logic              m_axi_awvalid, m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;
  logic              m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  native_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fixed attribute fields as one packed word: id,len,size,burst,lock,cache,prot,qos
  localparam logic [25:0] EXP_ATTR = {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'd0};

  // ---------------- slave model ----------------
  // Delay knobs: cycles a channel stalls after its partner raises valid;
  // a negative value picks 0..3 at random per transfer.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_inj = 2'b00, rresp_inj = 2'b00;

  logic [31:0] slv_mem [0:15];
  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit   aw_got, w_got, b_pend, r_pend;
  logic [31:0] s_waddr, s_wdata, s_raddr;
  logic [3:0]  s_wstrb;
  bit   p_awv, p_wv, p_arv, p_br, p_rr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  int   n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int   awv_cycles = 0, wv_cycles = 0;

  function automatic int pick(input int d);
    return (d < 0) ? int'($urandom_range(0, 3)) : d;
  endfunction

  // Runs once per falling edge. Handshakes are judged from what both sides
  // showed at the previous falling edge, which is what the rising edge saw.
  task automatic slave_step();
    if (reset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0;
      m_axi_rdata = 0; m_axi_rlast = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
      return;
    end
    // a stalled valid must hold itself and its payload
    if (p_awv && !m_axi_awready) check_val("aw_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
    if (p_wv && !m_axi_wready)   check_val("w_stable", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb}, {1'b1, p_wdata, p_wstrb});
    if (p_arv && !m_axi_arready) check_val("ar_stable", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});

    if (p_awv && m_axi_awready) begin
      aw_got = 1; s_waddr = p_awaddr; n_aw++;
      check_val("aw_attr", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                            m_axi_awcache, m_axi_awprot, m_axi_awqos}, EXP_ATTR);
    end
    if (p_wv && m_axi_wready) begin
      w_got = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; n_w++;
      check_val("wlast", m_axi_wlast, 1);
    end
    if (p_arv && m_axi_arready) begin
      r_pend = 1; r_cnt = pick(r_dly); s_raddr = p_araddr; n_ar++;
      check_val("ar_attr", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                            m_axi_arcache, m_axi_arprot, m_axi_arqos}, EXP_ATTR);
    end
    if (p_br && m_axi_bvalid) begin n_b++; m_axi_bvalid = 0; b_pend = 0; end
    if (p_rr && m_axi_rvalid) begin n_r++; m_axi_rvalid = 0; r_pend = 0; end
    if (aw_got && w_got) begin
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) slv_mem[s_waddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
      aw_got = 0; w_got = 0; b_pend = 1; b_cnt = pick(b_dly);
    end

    if (b_pend && !m_axi_bvalid) begin
      if (b_cnt == 0) begin m_axi_bvalid = 1; m_axi_bresp = bresp_inj; end
      else b_cnt--;
    end
    if (r_pend && !m_axi_rvalid) begin
      if (r_cnt == 0) begin
        m_axi_rvalid = 1; m_axi_rdata = slv_mem[s_raddr[5:2]];
        m_axi_rresp = rresp_inj; m_axi_rlast = 1;
      end else r_cnt--;
    end

    if (!m_axi_awvalid) begin m_axi_awready = 0; aw_cnt = pick(aw_dly); end
    else if (m_axi_awready) m_axi_awready = 0;
    else if (aw_cnt == 0) m_axi_awready = 1;
    else aw_cnt--;
    if (!m_axi_wvalid) begin m_axi_wready = 0; w_cnt = pick(w_dly); end
    else if (m_axi_wready) m_axi_wready = 0;
    else if (w_cnt == 0) m_axi_wready = 1;
    else w_cnt--;
    if (!m_axi_arvalid) begin m_axi_arready = 0; ar_cnt = pick(ar_dly); end
    else if (m_axi_arready) m_axi_arready = 0;
    else if (ar_cnt == 0) m_axi_arready = 1;
    else ar_cnt--;

    if (m_axi_awvalid) awv_cycles++;
    if (m_axi_wvalid)  wv_cycles++;
    p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_arv = m_axi_arvalid;
    p_br = m_axi_bready; p_rr = m_axi_rready;
    p_awaddr = m_axi_awaddr; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
    p_araddr = m_axi_araddr;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      slave_step();
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:15];
  logic [31:0] last_rd = 32'h0;
  bit          err_exp = 0;

  // One native transaction; exp_lat < 0 skips the latency check.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int exp_lat);
    int   lat;
    bit   got;
    int   aw0, w0, b0, ar0, r0;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    @(negedge clk);
    valid = 1; addr = a; wdata = d; wstrb = s;
    awv_cycles = 0; wv_cycles = 0;
    lat = 0; got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ready) got = 1;
    end
    valid = 0;
    check_val("ready_seen", got, 1);
    if (exp_lat >= 0) check_val("latency", lat, exp_lat);
    if (s != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      if (bresp_inj != 2'b00) err_exp = 1;
      check_val("awaddr", s_waddr, wa);
      check_val("wbeat", {s_wdata, s_wstrb}, {d, s});
      check_val("rdata_hold", rdata, last_rd);
    end else begin
      last_rd = ref_mem[a[5:2]];
      if (rresp_inj != 2'b00) err_exp = 1;
      check_val("araddr", s_raddr, wa);
      check_val("rdata", rdata, last_rd);
    end
    check_val("err", err, err_exp);
    @(negedge clk);
    check_val("ready_pulse", ready, 0);
    if (s != 4'd0)
      check_val("wr_beats", {n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0}, {32'd1, 32'd1, 32'd1, 32'd0});
    else
      check_val("rd_beats", {n_ar - ar0, n_r - r0, n_aw - aw0}, {32'd1, 32'd1, 32'd0});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, {ready, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                              m_axi_arvalid, m_axi_rready}, 7'd0);
    check_val({tag, "_rdata"}, rdata, 0);
    check_val({tag, "_addr"}, {m_axi_awaddr, m_axi_araddr}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    reset = 1; valid = 0; addr = 0; wdata = 0; wstrb = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0;
    m_axi_rdata = 0; m_axi_rlast = 0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 0;

    // zero-wait write then read back, both at three-cycle latency
    run_txn(32'h100, 32'hDEADBEEF, 4'hF, 3);
    run_txn(32'h100, 32'h0, 4'h0, 3);
    check_val("readback", rdata, 32'hDEADBEEF);

    // unaligned half-word write aligns the address and merges lanes
    run_txn(32'h103, 32'h12345678, 4'h3, 3);
    run_txn(32'h100, 32'h0, 4'h0, 3);
    check_val("merge", rdata, 32'hDEAD5678);

    // AW stalled: awvalid up five cycles, W accepted at once
    aw_dly = 4;
    run_txn(32'h108, 32'hA5A5A5A5, 4'hF, 7);
    check_val("awv_cycles", awv_cycles, 5);
    check_val("wv_cycles", wv_cycles, 1);
    aw_dly = 0;

    // SLVERR on a read sets err, later OKAY traffic leaves it set
    rresp_inj = 2'b10;
    run_txn(32'h108, 32'h0, 4'h0, 3);
    rresp_inj = 2'b00;
    run_txn(32'h10C, 32'h0BADF00D, 4'hF, 3);
    run_txn(32'h10C, 32'h0, 4'h0, 3);
    check_val("err_sticky", err, 1);

    // reset while waiting on R abandons the read
    r_dly = 20;
    @(negedge clk);
    valid = 1; addr = 32'h104; wdata = 0; wstrb = 0;
    repeat (3) @(negedge clk);
    check_val("in_rd_data", m_axi_rready, 1);
    reset = 1; valid = 0;
    #1;
    check_all_zero("mid_reset");
    err_exp = 0; last_rd = 32'h0;
    repeat (2) @(negedge clk);
    reset = 0;
    r_dly = 0;
    run_txn(32'h100, 32'h0, 4'h0, 3);

    // randomized traffic with random backpressure and occasional error responses
    aw_dly = -1; w_dly = -1; ar_dly = -1; b_dly = -1; r_dly = -1;
    for (int t = 0; t < 120; t++) begin
      a = 32'h100 + $urandom_range(0, 63);
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bresp_inj = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
      rresp_inj = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
      run_txn(a, d, s, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
